// File: rtl/pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_unit
// Function : Scoreboard RAW interlock and taken-branch flush sequencer
//            for the decode stage. Optional macro: FORWARDING_EN.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_unit #(
  parameter int REGNUM       = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int WB_DEPTH     = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issueValid,
  input  logic [ADDRESSWIDTH-1:0] issueSrcA,
  input  logic [ADDRESSWIDTH-1:0] issueSrcB,
  input  logic                    issueSrcAUsed,
  input  logic                    issueSrcBUsed,
  input  logic [ADDRESSWIDTH-1:0] issueDst,
  input  logic                    issueDstWrite,
  input  logic                    issueIsLoad,
  input  logic                    branchTaken,
  output logic                    stall,
  output logic                    flush,
  output logic                    issueFire,
  output logic [REGNUM-1:0]       busyMask
);

  localparam logic [2:0] WB_LOAD    = 3'(WB_DEPTH);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [2:0]        fcnt;
  logic [2:0]        fcnt_next;
  logic [2:0]        cnt [REGNUM];
  logic [REGNUM-1:0] ld;
  logic [REGNUM-1:0] reg_hazard;
  logic              in_run;
  logic              hazard_a;
  logic              hazard_b;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_RUN;
      fcnt  <= 3'd0;
    end else begin
      state <= state_next;
      fcnt  <= fcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    unique case (state)
      ST_RUN: begin
        if (branchTaken) begin
          state_next = ST_FLUSH;
          fcnt_next  = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        // Squashed instructions cannot branch, so branchTaken is ignored here.
        fcnt_next = fcnt - 3'd1;
        if (fcnt == 3'd1) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
        fcnt_next  = 3'd0;
      end
    endcase
  end

  assign in_run = (state == ST_RUN);
  assign flush  = (state == ST_FLUSH);

  // ---------------------------------------------------------- scoreboard
  // A new issue to a register overrides the decrement (WAW reload).
  always_ff @(posedge clock) begin
    for (int r = 0; r < REGNUM; r++) begin
      if (reset) begin
        cnt[r] <= 3'd0;
        ld[r]  <= 1'b0;
      end else if (issueFire && issueDstWrite && (issueDst == ADDRESSWIDTH'(r))) begin
        cnt[r] <= WB_LOAD;
        ld[r]  <= issueIsLoad;
      end else if (cnt[r] != 3'd0) begin
        cnt[r] <= cnt[r] - 3'd1;
      end
    end
  end

  for (genvar r = 0; r < REGNUM; r++) begin : g_reg
    assign busyMask[r] = (cnt[r] != 3'd0);
`ifdef FORWARDING_EN
    // Only a load still in its first post-issue cycle cannot be bypassed.
    assign reg_hazard[r] = (cnt[r] == WB_LOAD) & ld[r];
`else
    assign reg_hazard[r] = busyMask[r];
`endif
  end

`ifndef FORWARDING_EN
  logic ld_unused;
  assign ld_unused = ^ld;
`endif

  // ---------------------------------------------------------- issue gating
  assign hazard_a  = issueSrcAUsed & reg_hazard[issueSrcA];
  assign hazard_b  = issueSrcBUsed & reg_hazard[issueSrcB];
  assign stall     = issueValid & in_run & (hazard_a | hazard_b) & ~reset;
  assign issueFire = issueValid & in_run & ~(hazard_a | hazard_b) & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
`default_nettype none
// Testbench for pipeline_hazard_unit: directed scenarios then random traffic,
// checked against a timestamp-based reference model.
module tb_pipeline_hazard_unit;

  localparam int REGNUM = 16;
  localparam int AW     = 4;
  localparam int WB     = 3;
  localparam int FC     = 2;

  logic          clock;
  logic          reset;
  logic          issueValid;
  logic [AW-1:0] issueSrcA;
  logic [AW-1:0] issueSrcB;
  logic          issueSrcAUsed;
  logic          issueSrcBUsed;
  logic [AW-1:0] issueDst;
  logic          issueDstWrite;
  logic          issueIsLoad;
  logic          branchTaken;
  logic          stall;
  logic          flush;
  logic          issueFire;
  logic [REGNUM-1:0] busyMask;

  pipeline_hazard_unit #(
    .REGNUM(REGNUM), .ADDRESSWIDTH(AW), .WB_DEPTH(WB), .FLUSH_CYCLES(FC)
  ) dut (
    .clock(clock), .reset(reset), .issueValid(issueValid),
    .issueSrcA(issueSrcA), .issueSrcB(issueSrcB),
    .issueSrcAUsed(issueSrcAUsed), .issueSrcBUsed(issueSrcBUsed),
    .issueDst(issueDst), .issueDstWrite(issueDstWrite),
    .issueIsLoad(issueIsLoad), .branchTaken(branchTaken),
    .stall(stall), .flush(flush), .issueFire(issueFire), .busyMask(busyMask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a register is busy for the WB cycles following the
  // cycle in which its producer fired; a flush covers the FC cycles after
  // an accepted branch.
  int compared;
  int mismatched;
  int t;
  int fire_cyc [REGNUM];
  bit is_load  [REGNUM];
  int flush_end;
  logic last_stall;
  logic last_fire;
  logic last_flush;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic model_clear();
    for (int r = 0; r < REGNUM; r++) begin
      fire_cyc[r] = -100;
      is_load[r]  = 1'b0;
    end
    flush_end = -1;
  endtask

  function automatic bit m_hazard(input int r);
    int age;
    age = t - fire_cyc[r];
    if (FWD) return (age == 1) && is_load[r];
    return (age >= 1) && (age <= WB);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [AW-1:0] a, input logic au,
                      input logic [AW-1:0] b, input logic bu, input logic [AW-1:0] d,
                      input logic dw, input logic il, input logic br, input logic rs);
    bit in_flush, haz, e_stall, e_fire;
    logic [REGNUM-1:0] e_busy;
    int age;
    @(negedge clock);
    issueValid = v; issueSrcA = a; issueSrcAUsed = au; issueSrcB = b;
    issueSrcBUsed = bu; issueDst = d; issueDstWrite = dw; issueIsLoad = il;
    branchTaken = br; reset = rs;
    #1;
    in_flush = (t <= flush_end);
    haz      = (au && m_hazard(int'(a))) || (bu && m_hazard(int'(b)));
    e_stall  = v && !in_flush && haz && !rs;
    e_fire   = v && !in_flush && !haz && !rs;
    for (int r = 0; r < REGNUM; r++) begin
      age = t - fire_cyc[r];
      e_busy[r] = (age >= 1) && (age <= WB);
    end
    chk("stall", 32'(stall), 32'(e_stall));
    chk("issueFire", 32'(issueFire), 32'(e_fire));
    chk("flush", 32'(flush), 32'(in_flush));
    chk("busyMask", 32'(busyMask), 32'(e_busy));
    last_stall = stall; last_fire = issueFire; last_flush = flush;
    if (rs) begin
      model_clear();
    end else begin
      if (e_fire && dw) begin
        fire_cyc[d] = t;
        is_load[d]  = il;
      end
      if (!in_flush && br) flush_end = t + FC;
    end
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int stalls;
  int flushes;

  initial begin
    compared = 0; mismatched = 0; t = 0;
    model_clear();
    reset = 1'b1; issueValid = 0; issueSrcA = 0; issueSrcB = 0;
    issueSrcAUsed = 0; issueSrcBUsed = 0; issueDst = 0; issueDstWrite = 0;
    issueIsLoad = 0; branchTaken = 0;
    repeat (2) @(posedge clock);

    // Reset state and RAW interlock on R5 behind an ALU producer.
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 5, 1, 0, 0, 1, 0, 0, 0, 0);
      if (last_fire) break;
      if (last_stall) stalls++;
    end
    chk("alu_use_stalls", 32'(stalls), FWD ? 32'd0 : 32'(WB));
    chk("alu_use_fired", 32'(last_fire), 32'd1);
    idle(4);

    // Load-use dependency on R5 via source B.
    step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 5, 1, 2, 1, 0, 0, 0);
      if (last_fire) break;
      if (last_stall) stalls++;
    end
    chk("load_use_stalls", 32'(stalls), FWD ? 32'd1 : 32'(WB));
    idle(4);

    // Unused busy source does not stall.
    step(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    step(1, 7, 0, 7, 0, 8, 1, 0, 0, 0);
    chk("unused_src_fire", 32'(last_fire), 32'd1);
    idle(4);

    // Branch with a second branch during the flush window.
    step(1, 0, 0, 0, 0, 9, 1, 0, 1, 0);
    flushes = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 2, 0, 4, 1, 0, (i == 0), 0);
      if (last_flush) flushes++;
    end
    chk("flush_len", 32'(flushes), 32'(FC));
    idle(4);

    // WAW reload of R3.
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    idle(5);

    // Reset in the middle of a flush with R5 busy.
    step(1, 0, 0, 0, 0, 5, 1, 0, 1, 0);
    step(1, 5, 1, 5, 1, 6, 1, 0, 0, 1);
    chk("reset_fire", 32'(last_fire), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_reset_busy", 32'(busyMask), 32'd0);
    chk("post_reset_flush", 32'(last_flush), 32'd0);

    // Random traffic over a small register window to force collisions.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0),
           AW'($urandom_range(0, 7)), 1'($urandom),
           AW'($urandom_range(0, 7)), 1'($urandom),
           AW'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0), 1'($urandom),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Scoreboard-based hazard and flush controller for the 16-register pipelined CPU. Sits beside the decode stage. Tracks which registers have in-flight writebacks and stalls decode while a used source is pending. Sequences a fixed-length pipeline flush after a taken branch and gates instruction issue.

## Interface
Parameters:
- REGNUM, 16, number of architectural registers
- ADDRESSWIDTH, 4, register index width
- WB_DEPTH, 3, cycles from issue to register-file writeback; range 1..7
- FLUSH_CYCLES, 2, bubbles injected after a taken branch; range 1..7

Ports:
- clock  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-high reset
- issueValid  in  1  decode holds a valid instruction
- issueSrcA, issueSrcB  in  ADDRESSWIDTH  source register indices
- issueSrcAUsed, issueSrcBUsed  in  1  the corresponding source is actually read
- issueDst  in  ADDRESSWIDTH  destination register index
- issueDstWrite  in  1  the instruction writes issueDst
- issueIsLoad  in  1  the instruction is a memory load
- branchTaken  in  1  execute resolved a taken branch this cycle
- stall  out  1  hold fetch/decode and inject a bubble
- flush  out  1  squash fetch/decode contents
- issueFire  out  1  the decode instruction advances this cycle
- busyMask  out  REGNUM  bit r = register r has a pending writeback

## Operation
- Per-register counter cnt[r], width 3; busyMask[r] = (cnt[r] != 0). Per-register flag ld[r] marks a load producer.
- hazardX = issueSrcXUsed & hazard(issueSrcX), for X in {A, B}.
- Without FORWARDING_EN: hazard(r) = (cnt[r] != 0).
- stall = issueValid & (state == RUN) & (hazardA | hazardB) & ~reset.
- issueFire = issueValid & (state == RUN) & ~stall & ~reset.
- Every edge, each nonzero cnt[r] decrements by 1.
- On an edge with issueFire & issueDstWrite: cnt[issueDst] <= WB_DEPTH and ld[issueDst] <= issueIsLoad. This load wins over the decrement for the same register.
- WAW: issuing to a busy register reloads its counter and flag. No stall.
- Register 0 is not special and is tracked like the others.
- FSM states:
  - RUN: flush = 0. branchTaken → FLUSH, with fcnt <= FLUSH_CYCLES.
  - FLUSH: flush = 1. fcnt decrements each edge. Return to RUN on the edge where fcnt == 1. branchTaken is ignored here because squashed instructions cannot branch.
- flush is a registered output (flush = (state == FLUSH)).
- During FLUSH, issueFire = 0, stall = 0 and no scoreboard entries are set. Counters of older in-flight instructions keep decrementing.
- branchTaken takes priority over issue in the same cycle: the instruction that issues that cycle is the last one issued before the flush.

## Timing
- Reset (synchronous, sampled at the edge): all cnt = 0, all ld = 0, state = RUN, fcnt = 0. After that edge, busyMask = 0 and flush = 0. While reset is high, stall = 0 and issueFire = 0.
- stall and issueFire are combinational from the issue inputs and registered state, with zero latency. flush and busyMask are registered.
- Dependent instruction behind a writer, without forwarding: exactly WB_DEPTH stall cycles when it arrives in decode on the cycle after the producer fires.
- Flush: branchTaken high at cycle k → flush high for cycles k+1 .. k+FLUSH_CYCLES, then RUN.
- Reset asserted mid-flush or mid-stall aborts everything on that edge.

## Configuration
- FORWARDING_EN defined: hazard(r) = (cnt[r] == WB_DEPTH) & ld[r]. Non-load dependencies never stall. A load-use dependency stalls exactly 1 cycle.
- FORWARDING_EN undefined: hazard(r) = (cnt[r] != 0), with full writeback interlock. ld[] is still maintained but unused.

## Test plan
WB_DEPTH = 3, FLUSH_CYCLES = 2 throughout.
- RAW interlock, no macro: fire dst = R5 (write) at cycle 0; srcA = R5 used from cycle 1 → stall = 1 in cycles 1–3; issueFire = 1 at cycle 4; busyMask = 0x0020 in cycles 1–3.
- FORWARDING_EN: ALU producer to R5 followed by a consumer of R5 → 0 stall cycles. Load producer to R5 followed by a consumer → exactly 1 stall cycle, then fire.
- Unused source: R7 busy, srcA = R7 with issueSrcAUsed = 0 → stall = 0 and issueFire = 1.
- Branch: branchTaken at cycle 10 → flush = 1 in cycles 11–12 and issueFire = 0 there. A second branchTaken at cycle 11 is ignored, and flush drops at cycle 13.
- WAW reload: fire dst = R3 at cycle 0 and again at cycle 1 → cnt[R3] = 3 at cycle 2, and busyMask bit 3 clears at cycle 5.
- Reset mid-operation: busyMask = 0x0020 and state FLUSH, reset high for one edge → next cycle busyMask = 0, flush = 0, and stall/issueFire = 0 while reset is high.
